gate_sensor_fsm: RTL and testbench



---
 rtl/parking_pkg.sv | 21 ++
 rtl/gate_sensor_fsm_if.sv | 25 ++
 rtl/sensor_debounce.sv | 40 ++++
 rtl/gate_sensor_fsm.sv | 151 +++++++++++++++
 tb/tb_gate_sensor_fsm.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared types and sensor encodings for the gate sensor front end of the car tracker.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENT_A,
    ENT_B,
    ENT_C,
    EXT_A,
    EXT_B,
    EXT_C,
    ERR
  } gate_state_t;

  // Sensor pattern s = {outer, inner}; 1 = beam blocked.
  localparam logic [1:0] S_CLEAR = 2'b00;
  localparam logic [1:0] S_OUTER = 2'b10;
  localparam logic [1:0] S_BOTH  = 2'b11;
  localparam logic [1:0] S_INNER = 2'b01;

endpackage

// File: rtl/gate_sensor_fsm_if.sv
// Gate bundle: raw beam inputs in, passage pulses and occupancy status out.
interface gate_sensor_fsm_if #(
  parameter int unsigned CAPACITY = 3
);
  localparam int unsigned OCC_W = $clog2(CAPACITY + 1);

  logic             sensor_outer;
  logic             sensor_inner;
  logic             car_enter;
  logic             car_exit;
  logic [OCC_W-1:0] occupancy;
  logic             lot_full;
  logic             lot_empty;
  logic             seq_error;

  modport master (
    output sensor_outer, sensor_inner,
    input  car_enter, car_exit, occupancy, lot_full, lot_empty, seq_error
  );

  modport slave (
    input  sensor_outer, sensor_inner,
    output car_enter, car_exit, occupancy, lot_full, lot_empty, seq_error
  );
endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability counter; the filtered level only
// moves after the synchronised level has disagreed with it for DEBOUNCE_CYCLES cycles.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= raw;
      r_sync <= r_meta;
      if (r_sync == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
        r_filt <= r_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign filtered = r_filt;
endmodule

// File: rtl/gate_sensor_fsm.sv
// Direction-resolving gate FSM: classifies debounced beam sequences as entries or exits
// and keeps a saturating lot occupancy count.
module gate_sensor_fsm
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  gate_sensor_fsm_if.slave bus
);
  localparam int unsigned OCC_W = $clog2(CAPACITY + 1);
  localparam logic [OCC_W-1:0] OccMax = OCC_W'(CAPACITY);

  logic             w_outer_f;
  logic             w_inner_f;
  logic [1:0]       w_s;
  gate_state_t      r_state;
  gate_state_t      w_state_d;
  logic             w_enter;
  logic             w_exit;
  logic             w_seq_err;
  logic             w_err_d;
  logic [OCC_W-1:0] w_occ_d;
  logic [OCC_W-1:0] r_occ;
  logic             r_car_enter;
  logic             r_car_exit;
  logic             r_seq_error;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_outer (
    .clk      (clk),
    .reset    (reset),
    .raw      (bus.sensor_outer),
    .filtered (w_outer_f)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inner (
    .clk      (clk),
    .reset    (reset),
    .raw      (bus.sensor_inner),
    .filtered (w_inner_f)
  );

  assign w_s = {w_outer_f, w_inner_f};

  always_comb begin
    w_state_d = r_state;
    w_enter   = 1'b0;
    w_exit    = 1'b0;
    w_seq_err = 1'b0;
    unique case (r_state)
      IDLE: begin
        case (w_s)
          S_OUTER: w_state_d = ENT_A;
          S_INNER: w_state_d = EXT_A;
          S_BOTH:  begin w_state_d = ERR; w_seq_err = 1'b1; end
          default: w_state_d = IDLE;
        endcase
      end
      ENT_A: begin
        case (w_s)
          S_BOTH:  w_state_d = ENT_B;
          S_CLEAR: w_state_d = IDLE;
          S_INNER: begin w_state_d = ERR; w_seq_err = 1'b1; end
          default: w_state_d = ENT_A;
        endcase
      end
      ENT_B: begin
        case (w_s)
          S_INNER: w_state_d = ENT_C;
          S_OUTER: w_state_d = ENT_A;
          S_CLEAR: begin w_state_d = ERR; w_seq_err = 1'b1; end
          default: w_state_d = ENT_B;
        endcase
      end
      ENT_C: begin
        case (w_s)
          S_CLEAR: begin w_state_d = IDLE; w_enter = 1'b1; end
          S_BOTH:  w_state_d = ENT_B;
          S_OUTER: begin w_state_d = ERR; w_seq_err = 1'b1; end
          default: w_state_d = ENT_C;
        endcase
      end
      EXT_A: begin
        case (w_s)
          S_BOTH:  w_state_d = EXT_B;
          S_CLEAR: w_state_d = IDLE;
          S_OUTER: begin w_state_d = ERR; w_seq_err = 1'b1; end
          default: w_state_d = EXT_A;
        endcase
      end
      EXT_B: begin
        case (w_s)
          S_OUTER: w_state_d = EXT_C;
          S_INNER: w_state_d = EXT_A;
          S_CLEAR: begin w_state_d = ERR; w_seq_err = 1'b1; end
          default: w_state_d = EXT_B;
        endcase
      end
      EXT_C: begin
        case (w_s)
          S_CLEAR: begin w_state_d = IDLE; w_exit = 1'b1; end
          S_BOTH:  w_state_d = EXT_B;
          S_INNER: begin w_state_d = ERR; w_seq_err = 1'b1; end
          default: w_state_d = EXT_C;
        endcase
      end
      ERR: begin
        if (w_s == S_CLEAR) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Saturate at both ends; a pulse that cannot move the count is flagged instead.
  always_comb begin
    w_occ_d = r_occ;
    w_err_d = w_seq_err;
    if (w_enter) begin
      if (r_occ == OccMax) w_err_d = 1'b1;
      else                 w_occ_d = r_occ + 1'b1;
    end else if (w_exit) begin
      if (r_occ == '0) w_err_d = 1'b1;
      else             w_occ_d = r_occ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_occ       <= '0;
      r_car_enter <= 1'b0;
      r_car_exit  <= 1'b0;
      r_seq_error <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_occ       <= w_occ_d;
      r_car_enter <= w_enter;
      r_car_exit  <= w_exit;
      r_seq_error <= w_err_d;
    end
  end

  assign bus.car_enter = r_car_enter;
  assign bus.car_exit  = r_car_exit;
  assign bus.seq_error = r_seq_error;
  assign bus.occupancy = r_occ;
  assign bus.lot_full  = (r_occ == OccMax);
  assign bus.lot_empty = (r_occ == '0);
endmodule

// File: tb/tb_gate_sensor_fsm.sv
// Scoreboard bench for gate_sensor_fsm: directed passages push expected pulse events,
// a negedge monitor pops and compares every pulse the DUT emits.
module tb_gate_sensor_fsm;
  logic clk;
  logic reset;

  gate_sensor_fsm_if #(.CAPACITY(3)) bus_if ();

  gate_sensor_fsm #(
    .CAPACITY        (3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       enter;
    logic       ext;
    logic       err;
    logic [1:0] occ;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input logic en, input logic ex, input logic er, input logic [1:0] occ);
    exp_t e;
    e.enter = en;
    e.ext   = ex;
    e.err   = er;
    e.occ   = occ;
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic [1:0] s, input int n);
    @(negedge clk);
    bus_if.sensor_outer = s[1];
    bus_if.sensor_inner = s[0];
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic entry();
    apply(2'b10, 10);
    apply(2'b11, 10);
    apply(2'b01, 10);
    apply(2'b00, 10);
  endtask

  task automatic exit_pass();
    apply(2'b01, 10);
    apply(2'b11, 10);
    apply(2'b10, 10);
    apply(2'b00, 10);
  endtask

  // Monitor: any pulse must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_if.car_enter && bus_if.car_exit) begin
        checks++;
        errors++;
        $display("FAIL exclusive: car_enter and car_exit both high");
      end
      if (bus_if.car_enter || bus_if.car_exit || bus_if.seq_error) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got enter=%0b exit=%0b err=%0b occ=%0d, none expected",
                   bus_if.car_enter, bus_if.car_exit, bus_if.seq_error, bus_if.occupancy);
        end else begin
          e = exp_q.pop_front();
          check("pulse_enter", int'(bus_if.car_enter), int'(e.enter));
          check("pulse_exit", int'(bus_if.car_exit), int'(e.ext));
          check("pulse_seq_error", int'(bus_if.seq_error), int'(e.err));
          check("pulse_occupancy", int'(bus_if.occupancy), int'(e.occ));
        end
      end
    end
  end

  initial begin
    int k;
    bus_if.sensor_outer = 1'b0;
    bus_if.sensor_inner = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("reset_occupancy", int'(bus_if.occupancy), 0);
    check("reset_lot_empty", int'(bus_if.lot_empty), 1);
    check("reset_lot_full", int'(bus_if.lot_full), 0);
    check("reset_pulses", int'({bus_if.car_enter, bus_if.car_exit, bus_if.seq_error}), 0);

    // 1: single entry with pulse latency measured from the final clear.
    push(1'b1, 1'b0, 1'b0, 2'd1);
    apply(2'b10, 10);
    apply(2'b11, 10);
    apply(2'b01, 10);
    @(negedge clk);
    bus_if.sensor_outer = 1'b0;
    bus_if.sensor_inner = 1'b0;
    k = 0;
    while (!bus_if.car_enter && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("enter_latency", k, 7);
    repeat (5) @(negedge clk);
    check("s1_occupancy", int'(bus_if.occupancy), 1);
    check("s1_lot_empty", int'(bus_if.lot_empty), 0);

    // 2: fill the lot, overflow, then one exit.
    push(1'b1, 1'b0, 1'b0, 2'd2);
    entry();
    push(1'b1, 1'b0, 1'b0, 2'd3);
    entry();
    check("s2_lot_full", int'(bus_if.lot_full), 1);
    check("s2_occupancy_full", int'(bus_if.occupancy), 3);
    push(1'b1, 1'b0, 1'b1, 2'd3);
    entry();
    check("s2_occupancy_sat", int'(bus_if.occupancy), 3);
    push(1'b0, 1'b1, 1'b0, 2'd2);
    exit_pass();
    check("s2_occupancy_exit", int'(bus_if.occupancy), 2);
    check("s2_lot_full_clear", int'(bus_if.lot_full), 0);

    // 3: back-out and reversal produce nothing.
    apply(2'b10, 10);
    apply(2'b00, 10);
    apply(2'b10, 10);
    apply(2'b11, 10);
    apply(2'b10, 10);
    apply(2'b00, 10);
    check("s3_occupancy", int'(bus_if.occupancy), 2);

    // 4: 3-cycle glitch is filtered; 5-cycle glitch qualifies then backs out.
    apply(2'b10, 3);
    apply(2'b00, 10);
    apply(2'b10, 5);
    apply(2'b00, 12);
    check("s4_occupancy", int'(bus_if.occupancy), 2);

    // 5: illegal 00->11, then drain to 0 and underflow with a valid exit.
    push(1'b0, 1'b0, 1'b1, 2'd2);
    apply(2'b11, 10);
    apply(2'b00, 10);
    push(1'b0, 1'b1, 1'b0, 2'd1);
    exit_pass();
    push(1'b0, 1'b1, 1'b0, 2'd0);
    exit_pass();
    push(1'b0, 1'b1, 1'b1, 2'd0);
    exit_pass();
    check("s5_occupancy", int'(bus_if.occupancy), 0);
    check("s5_lot_empty", int'(bus_if.lot_empty), 1);

    // 6: reset mid-entry at occupancy 2, then an exit-path fragment.
    push(1'b1, 1'b0, 1'b0, 2'd1);
    entry();
    push(1'b1, 1'b0, 1'b0, 2'd2);
    entry();
    apply(2'b10, 10);
    apply(2'b11, 10);
    check("s6_occupancy_pre", int'(bus_if.occupancy), 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("s6_occupancy_reset", int'(bus_if.occupancy), 0);
    check("s6_lot_empty_reset", int'(bus_if.lot_empty), 1);
    reset = 1'b0;
    bus_if.sensor_outer = 1'b0;
    bus_if.sensor_inner = 1'b1;
    repeat (9) @(negedge clk);
    apply(2'b00, 15);
    check("s6_occupancy_post", int'(bus_if.occupancy), 0);

    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
